// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: sequences T0-T2 against a variable-latency memory,
// decodes HALT, and hands each fetched instruction to the execute controller.
module fetch_sequencer #(
    parameter int          MEM_TIMEOUT = 16,
    parameter int          WAIT_W      = 8,
    parameter int          COUNT_W     = 16,
    parameter logic [4:0]  HALT_OPCODE = 5'b11011
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    input  logic               stall,
    input  logic               mem_ready,
    input  logic               exec_done,
    input  logic [4:0]         ir_opcode,
    output logic               PC_out,
    output logic               MAR_in,
    output logic               IncPC,
    output logic               Z_in,
    output logic               Zlow_out,
    output logic               PC_in,
    output logic               Read,
    output logic               MDR_in,
    output logic               MDR_out,
    output logic               IR_in,
    output logic               exec_start,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    logic [COUNT_W-1:0]  instr_count_q;
    logic [COUNT_W-1:0]  instr_count_d;
    logic                fetch_hold;
    logic                is_halt;

    // Stall only freezes the fetch/decode steps; T1W and EXEC have a transaction in flight.
    assign fetch_hold = stall && (state_q == S_T0 || state_q == S_T1 ||
                                  state_q == S_T2 || state_q == S_DECODE);
    assign is_halt    = (ir_opcode == HALT_OPCODE);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;
        if (!fetch_hold) begin
            unique case (state_q)
                S_IDLE: begin
                    if (run) state_d = S_T0;
                end
                S_T0: begin
                    state_d = S_T1;
                end
                S_T1: begin
                    state_d    = S_T1W;
                    wait_cnt_d = '0;
                end
                S_T1W: begin
                    if (mem_ready) begin
                        state_d = S_T2;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_T2: begin
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    state_d = is_halt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_count_d = instr_count_q + COUNT_ONE;
                        state_d       = run ? S_T0 : S_IDLE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Control strobes decode straight from state so the datapath sees them in the same cycle.
    always_comb begin
        PC_out     = 1'b0;
        MAR_in     = 1'b0;
        IncPC      = 1'b0;
        Z_in       = 1'b0;
        Zlow_out   = 1'b0;
        PC_in      = 1'b0;
        Read       = 1'b0;
        MDR_in     = 1'b0;
        MDR_out    = 1'b0;
        IR_in      = 1'b0;
        exec_start = 1'b0;
        if (!fetch_hold) begin
            unique case (state_q)
                S_T0: begin
                    PC_out = 1'b1;
                    MAR_in = 1'b1;
                    IncPC  = 1'b1;
                    Z_in   = 1'b1;
                end
                S_T1: begin
                    Zlow_out = 1'b1;
                    PC_in    = 1'b1;
                    Read     = 1'b1;
                end
                S_T1W: begin
                    Read   = 1'b1;
                    MDR_in = mem_ready;
                end
                S_T2: begin
                    MDR_out = 1'b1;
                    IR_in   = 1'b1;
                end
                S_DECODE: begin
                    exec_start = !is_halt;
                end
                default: begin
                    exec_start = 1'b0;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    assign halted      = (state_q == S_HALT);
    assign fault       = (state_q == S_FAULT);
    assign instr_count = instr_count_q;

    always_comb begin
        assert ($onehot0({PC_out, Zlow_out, MDR_out}));
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: per-instruction plans expand into expected per-cycle
// strobe vectors and retired counts, compared against the DUT every cycle.
module tb_fetch_sequencer;

    localparam int         CW      = 4;
    localparam int         TMO     = 16;
    localparam logic [4:0] HALT_OP = 5'b11011;

    // {PC_out,MAR_in,IncPC,Z_in,Zlow_out,PC_in,Read,MDR_in,MDR_out,IR_in,exec_start,busy,halted,fault}
    localparam logic [13:0] V_IDLE    = 14'h0000;
    localparam logic [13:0] V_HOLD    = 14'h0004;
    localparam logic [13:0] V_T0      = 14'h3C04;
    localparam logic [13:0] V_T1      = 14'h0384;
    localparam logic [13:0] V_T1W     = 14'h0084;
    localparam logic [13:0] V_T1W_RDY = 14'h00C4;
    localparam logic [13:0] V_T2      = 14'h0034;
    localparam logic [13:0] V_DEC     = 14'h000C;
    localparam logic [13:0] V_HALT    = 14'h0002;
    localparam logic [13:0] V_FAULT   = 14'h0001;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic run = 1'b0;
    logic stall = 1'b0;
    logic mem_ready = 1'b0;
    logic exec_done = 1'b0;
    logic [4:0] ir_opcode = 5'd0;
    logic PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out, IR_in;
    logic exec_start, busy, halted, fault;
    logic [CW-1:0] instr_count;

    fetch_sequencer #(.MEM_TIMEOUT(TMO), .WAIT_W(8), .COUNT_W(CW), .HALT_OPCODE(HALT_OP)) dut (
        .clk(clk), .clr(clr), .run(run), .stall(stall), .mem_ready(mem_ready),
        .exec_done(exec_done), .ir_opcode(ir_opcode),
        .PC_out(PC_out), .MAR_in(MAR_in), .IncPC(IncPC), .Z_in(Z_in), .Zlow_out(Zlow_out),
        .PC_in(PC_in), .Read(Read), .MDR_in(MDR_in), .MDR_out(MDR_out), .IR_in(IR_in),
        .exec_start(exec_start), .busy(busy), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          stall;
        logic          mem_ready;
        logic          exec_done;
        logic          run;
        logic [4:0]    op;
        logic [13:0]   ctl;
        logic [CW-1:0] cnt;
    } cyc_t;

    typedef struct {
        int s0, s1, s2, sd, rl, el;
        bit halt, run_end, drop_t2, busy_stall;
    } instr_t;

    cyc_t plan[$];
    int   model_cnt;
    int   vectors;
    int   miscompares;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] any_op();
        return 5'($urandom);
    endfunction

    function automatic logic [4:0] nonhalt_op();
        logic [4:0] op;
        do op = 5'($urandom); while (op == HALT_OP);
        return op;
    endfunction

    function automatic void push(logic s, logic mr, logic ed, logic r, logic [4:0] op, logic [13:0] ctl);
        cyc_t c;
        c.stall = s; c.mem_ready = mr; c.exec_done = ed; c.run = r; c.op = op;
        c.ctl = ctl; c.cnt = CW'(model_cnt);
        plan.push_back(c);
    endfunction

    function automatic instr_t rand_instr();
        instr_t p;
        p.s0 = $urandom_range(0, 2); p.s1 = $urandom_range(0, 2);
        p.s2 = $urandom_range(0, 2); p.sd = $urandom_range(0, 2);
        p.rl = $urandom_range(0, TMO - 1); p.el = $urandom_range(0, 4);
        p.halt = 1'b0; p.run_end = 1'b1; p.drop_t2 = 1'b0; p.busy_stall = 1'b0;
        return p;
    endfunction

    // Expands one instruction (starting with the FSM about to be in T0) into per-cycle expectations.
    function automatic void plan_instr(instr_t p);
        logic pre, post, ign;
        for (int i = 0; i < p.s0; i++) push(1'b1, rb(), rb(), p.drop_t2 ? 1'b1 : rb(), any_op(), V_HOLD);
        push(1'b0, rb(), rb(), p.drop_t2 ? 1'b1 : rb(), any_op(), V_T0);
        for (int i = 0; i < p.s1; i++) push(1'b1, rb(), rb(), p.drop_t2 ? 1'b1 : rb(), any_op(), V_HOLD);
        push(1'b0, rb(), rb(), p.drop_t2 ? 1'b1 : rb(), any_op(), V_T1);
        for (int k = 0; k < p.rl && k < TMO; k++) begin
            ign = p.busy_stall ? 1'b1 : rb();
            pre = p.drop_t2 ? 1'b1 : rb();
            push(ign, 1'b0, rb(), pre, any_op(), V_T1W);
        end
        if (p.rl >= TMO) return;
        ign = p.busy_stall ? 1'b1 : rb();
        push(ign, 1'b1, rb(), p.drop_t2 ? 1'b1 : rb(), any_op(), V_T1W_RDY);
        for (int i = 0; i < p.s2; i++) push(1'b1, rb(), rb(), p.drop_t2 ? 1'b0 : rb(), any_op(), V_HOLD);
        push(1'b0, rb(), rb(), p.drop_t2 ? 1'b0 : rb(), any_op(), V_T2);
        for (int i = 0; i < p.sd; i++) push(1'b1, rb(), rb(), p.drop_t2 ? 1'b0 : rb(), any_op(), V_HOLD);
        post = p.drop_t2 ? 1'b0 : rb();
        push(1'b0, rb(), rb(), post, p.halt ? HALT_OP : nonhalt_op(), p.halt ? V_HOLD : V_DEC);
        if (p.halt) return;
        for (int i = 0; i < p.el; i++) begin
            ign = p.busy_stall ? 1'b1 : rb();
            push(ign, rb(), 1'b0, p.drop_t2 ? 1'b0 : rb(), any_op(), V_HOLD);
        end
        push(p.busy_stall ? 1'b1 : rb(), rb(), 1'b1, p.run_end, any_op(), V_HOLD);
        model_cnt = (model_cnt + 1) % (1 << CW);
    endfunction

    function automatic logic [13:0] obs();
        return {PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read, MDR_in, MDR_out, IR_in,
                exec_start, busy, halted, fault};
    endfunction

    task automatic apply_cycle(input cyc_t c, output logic [13:0] ctl, output logic [CW-1:0] cnt);
        stall = c.stall; mem_ready = c.mem_ready; exec_done = c.exec_done;
        run = c.run; ir_opcode = c.op;
        @(negedge clk);
        ctl = obs();
        cnt = instr_count;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0; run = 1'b0; stall = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        model_cnt = 0;
        plan.delete();
    endtask

    task automatic test_reset();
        logic [13:0] ctl; logic [CW-1:0] cnt;
        clr = 1'b0;
        #2;
        vectors++;
        if ({obs(), instr_count} !== {V_IDLE, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_poweron: got ctl=%h cnt=%0d, expected ctl=%h cnt=0", obs(), instr_count, V_IDLE);
        end
        do_reset();
        push(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, V_IDLE);
        begin
            instr_t p = rand_instr();
            plan_instr(p);
        end
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_T0);
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_T1);
        push(rb(), 1'b0, rb(), 1'b1, any_op(), V_T1W);
        push(rb(), 1'b0, rb(), 1'b1, any_op(), V_T1W);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL reset_pre cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
        mem_ready = 1'b0; run = 1'b1;
        clr = 1'b0;
        #2;
        vectors++;
        if ({obs(), instr_count} !== {V_IDLE, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_t1w: got ctl=%h cnt=%0d, expected ctl=%h cnt=0", obs(), instr_count, V_IDLE);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        model_cnt = 0;
        plan.delete();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        push(1'b0, rb(), rb(), rb(), any_op(), V_T0);
        push(1'b0, rb(), rb(), rb(), any_op(), V_T1);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL reset_release cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_basic_fetch();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        p = rand_instr();
        p.s0 = 0; p.s1 = 0; p.s2 = 0; p.sd = 0; p.rl = 2; p.el = 2; p.run_end = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, V_IDLE);
        plan_instr(p);
        push(1'b0, rb(), rb(), rb(), any_op(), V_T0);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL basic_fetch cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        for (int n = 0; n < 12; n++) begin
            p = rand_instr();
            p.run_end = (n != 11);
            plan_instr(p);
        end
        push(rb(), rb(), rb(), 1'b0, any_op(), V_IDLE);
        push(rb(), rb(), rb(), 1'b0, any_op(), V_IDLE);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL random_stream cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_stall();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        p = rand_instr();
        p.s0 = 3; p.s1 = 1; p.s2 = 1; p.sd = 2; p.rl = 3; p.el = 2;
        p.busy_stall = 1'b1; p.run_end = 1'b0;
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        plan_instr(p);
        push(1'b1, rb(), rb(), 1'b0, any_op(), V_IDLE);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL stall cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_timeout();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        p = rand_instr();
        p.rl = TMO - 1; p.run_end = 1'b1;
        plan_instr(p);
        p = rand_instr();
        p.rl = TMO;
        plan_instr(p);
        for (int i = 0; i < 3; i++) push(rb(), 1'b1, rb(), 1'b1, any_op(), V_FAULT);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL timeout cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_halt();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        p = rand_instr();
        p.run_end = 1'b1;
        plan_instr(p);
        p = rand_instr();
        p.halt = 1'b1;
        plan_instr(p);
        for (int i = 0; i < 3; i++) push(rb(), rb(), 1'b1, 1'b1, any_op(), V_HALT);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL halt cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        for (int n = 0; n < 16; n++) begin
            p = rand_instr();
            p.s0 = 0; p.s1 = 0; p.s2 = 0; p.sd = 0;
            p.rl = $urandom_range(0, 2); p.el = $urandom_range(0, 1);
            p.run_end = (n != 15);
            plan_instr(p);
        end
        push(rb(), rb(), rb(), 1'b0, any_op(), V_IDLE);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL count_wrap cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    task automatic test_run_drop();
        logic [13:0] ctl; logic [CW-1:0] cnt; instr_t p;
        do_reset();
        push(1'b0, rb(), rb(), 1'b1, any_op(), V_IDLE);
        p = rand_instr();
        p.drop_t2 = 1'b1; p.run_end = 1'b0;
        plan_instr(p);
        push(rb(), rb(), rb(), 1'b0, any_op(), V_IDLE);
        push(rb(), rb(), rb(), 1'b0, any_op(), V_IDLE);
        foreach (plan[i]) begin
            apply_cycle(plan[i], ctl, cnt);
            vectors++;
            if ({ctl, cnt} !== {plan[i].ctl, plan[i].cnt}) begin
                miscompares++;
                $display("[TB] FAIL run_drop cycle %0d: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl, cnt, plan[i].ctl, plan[i].cnt);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_cnt = 0;
        #3;
        test_reset();
        test_basic_fetch();
        test_random_stream();
        test_stall();
        test_timeout();
        test_halt();
        test_count_wrap();
        test_run_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
